// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: controller states and the
// default wait-state timeout.
package mem_access_sequencer_pkg;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;
   localparam int DEFAULT_TMR_W          = 8;

   typedef enum logic [3:0] {
      IDLE,
      F_ADDR,
      F_WAIT,
      F_IR,
      L_ADDR,
      L_WAIT,
      L_DATA,
      S_ADDR,
      S_DATA,
      S_WAIT,
      S_END,
      ERR
   } seq_state_t;

   function automatic logic is_wait_state(input seq_state_t s);
      return (s == F_WAIT) || (s == L_WAIT) || (s == S_WAIT);
   endfunction

endpackage

// File: rtl/mem_access_sequencer_wait_timer.sv
// Wait-state counter: restarts from zero, advances once per stalled cycle and
// flags when the last permitted stall cycle has been reached.
module mem_access_sequencer_wait_timer #(
   parameter int TMR_W          = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic clear,
   input  logic restart,
   input  logic advance,
   output logic expired
);

   logic [TMR_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clock) begin
      if (!clear) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (advance) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Moore controller sequencing PC/MAR/MDR/IR strobes and the memory handshake
// for instruction fetch, data load and data store, with a wait-state timeout.
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TMR_W          = DEFAULT_TMR_W
) (
   input  logic clock,
   input  logic clear,
   input  logic fetch_req,
   input  logic load_req,
   input  logic store_req,
   input  logic mem_ready,
   input  logic err_ack,
   output logic pc_out,
   output logic mar_in,
   output logic inc_pc,
   output logic mdr_read,
   output logic mdr_in,
   output logic mdr_out,
   output logic ir_in,
   output logic mem_read,
   output logic mem_write,
   output logic busy,
   output logic done,
   output logic err_timeout
);

   seq_state_t state;
   seq_state_t next_state;
   logic       timer_expired;

   // The counter idles at zero outside the wait states, so it is already
   // cleared on the first cycle of any *_WAIT state.
   mem_access_sequencer_wait_timer #(
      .TMR_W          (TMR_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clock   (clock),
      .clear   (clear),
      .restart (!is_wait_state(state)),
      .advance (is_wait_state(state) && !mem_ready),
      .expired (timer_expired)
   );

   always_ff @(posedge clock) begin
      if (!clear) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (store_req) begin
               next_state = S_ADDR;
            end else if (load_req) begin
               next_state = L_ADDR;
            end else if (fetch_req) begin
               next_state = F_ADDR;
            end
         end
         F_ADDR: next_state = F_WAIT;
         F_WAIT: begin
            if (mem_ready) begin
               next_state = F_IR;
            end else if (timer_expired) begin
               next_state = ERR;
            end
         end
         F_IR:   next_state = IDLE;
         L_ADDR: next_state = L_WAIT;
         L_WAIT: begin
            if (mem_ready) begin
               next_state = L_DATA;
            end else if (timer_expired) begin
               next_state = ERR;
            end
         end
         L_DATA: next_state = IDLE;
         S_ADDR: next_state = S_DATA;
         S_DATA: next_state = S_WAIT;
         S_WAIT: begin
            if (mem_ready) begin
               next_state = S_END;
            end else if (timer_expired) begin
               next_state = ERR;
            end
         end
         S_END:  next_state = IDLE;
         ERR: begin
            if (err_ack) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pc_out      = 1'b0;
      mar_in      = 1'b0;
      inc_pc      = 1'b0;
      mdr_read    = 1'b0;
      mdr_in      = 1'b0;
      mdr_out     = 1'b0;
      ir_in       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      done        = 1'b0;
      busy        = (state != IDLE) && (state != ERR);
      err_timeout = (state == ERR);
      case (state)
         F_ADDR: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
         end
         F_WAIT, L_WAIT: begin
            mem_read = 1'b1;
            mdr_read = 1'b1;
            mdr_in   = mem_ready;
         end
         F_IR: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
            done    = 1'b1;
         end
         L_ADDR, S_ADDR: mar_in = 1'b1;
         L_DATA: begin
            mdr_out = 1'b1;
            done    = 1'b1;
         end
         S_DATA: mdr_in    = 1'b1;
         S_WAIT: mem_write = 1'b1;
         S_END:  done      = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with TIMEOUT_CYCLES=4; every cycle
// compares the packed output vector against a hand-derived constant.
module tb_mem_access_sequencer;

   logic clock = 1'b0;
   logic clear, fetch_req, load_req, store_req, mem_ready, err_ack;
   logic pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in;
   logic mem_read, mem_write, busy, done, err_timeout;
   logic [11:0] outs;

   int n_checks = 0;
   int n_errors = 0;

   // Bit order: pc_out mar_in inc_pc mdr_read | mdr_in mdr_out ir_in mem_read |
   // mem_write busy done err_timeout
   localparam logic [11:0] O_IDLE   = 12'h000;
   localparam logic [11:0] O_F_ADDR = 12'hE04;
   localparam logic [11:0] O_WAIT   = 12'h114;
   localparam logic [11:0] O_WAIT_R = 12'h194;
   localparam logic [11:0] O_F_IR   = 12'h066;
   localparam logic [11:0] O_ADDR   = 12'h404;
   localparam logic [11:0] O_L_DATA = 12'h046;
   localparam logic [11:0] O_S_DATA = 12'h084;
   localparam logic [11:0] O_S_WAIT = 12'h00C;
   localparam logic [11:0] O_S_END  = 12'h006;
   localparam logic [11:0] O_ERR    = 12'h001;

   mem_access_sequencer #(
      .TIMEOUT_CYCLES (4),
      .TMR_W          (8)
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .fetch_req   (fetch_req),
      .load_req    (load_req),
      .store_req   (store_req),
      .mem_ready   (mem_ready),
      .err_ack     (err_ack),
      .pc_out      (pc_out),
      .mar_in      (mar_in),
      .inc_pc      (inc_pc),
      .mdr_read    (mdr_read),
      .mdr_in      (mdr_in),
      .mdr_out     (mdr_out),
      .ir_in       (ir_in),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout)
   );

   assign outs = {pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in,
                  mem_read, mem_write, busy, done, err_timeout};

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %03h expected %03h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, compare this cycle's outputs, then advance.
   task automatic step(input string tag, input logic clr, input logic s, input logic l,
                       input logic f, input logic r, input logic a,
                       input logic [11:0] exp);
      clear     = clr;
      store_req = s;
      load_req  = l;
      fetch_req = f;
      mem_ready = r;
      err_ack   = a;
      #1;
      check(tag, outs, exp);
      @(posedge clock);
      #1;
   endtask

   initial begin
      clear = 1'b0; fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
      mem_ready = 1'b0; err_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", outs, O_IDLE);

      // Fetch, mem_ready on the third wait cycle
      step("f_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
      step("f_addr",   1, 0, 0, 1, 0, 0, O_F_ADDR);
      step("f_wait1",  1, 0, 0, 1, 0, 0, O_WAIT);
      step("f_wait2",  1, 0, 0, 1, 0, 0, O_WAIT);
      step("f_wait3",  1, 0, 0, 1, 1, 0, O_WAIT_R);
      step("f_ir",     1, 0, 0, 0, 0, 0, O_F_IR);
      step("f_after",  1, 0, 0, 0, 0, 0, O_IDLE);

      // Load beats fetch; fetch accepted in the idle cycle after done
      step("lf_idle",  1, 0, 1, 1, 0, 0, O_IDLE);
      step("lf_addr",  1, 0, 1, 1, 0, 0, O_ADDR);
      step("lf_wait",  1, 0, 1, 1, 1, 0, O_WAIT_R);
      step("lf_data",  1, 0, 0, 1, 0, 0, O_L_DATA);
      step("lf_gap",   1, 0, 0, 1, 0, 0, O_IDLE);
      step("lf_faddr", 1, 0, 0, 1, 0, 0, O_F_ADDR);
      step("lf_fwait", 1, 0, 0, 1, 1, 0, O_WAIT_R);
      step("lf_fir",   1, 0, 0, 0, 0, 0, O_F_IR);
      step("lf_after", 1, 0, 0, 0, 0, 0, O_IDLE);

      // Store, mem_ready immediate; stray mem_ready outside S_WAIT is ignored
      step("s_idle",   1, 1, 0, 0, 0, 0, O_IDLE);
      step("s_addr",   1, 1, 0, 0, 1, 0, O_ADDR);
      step("s_data",   1, 1, 0, 0, 1, 0, O_S_DATA);
      step("s_wait",   1, 1, 0, 0, 1, 0, O_S_WAIT);
      step("s_end",    1, 0, 0, 0, 0, 0, O_S_END);
      step("s_after",  1, 0, 0, 0, 0, 0, O_IDLE);

      // Load timeout after four wait cycles; ERR ignores requests and mem_ready
      step("t_idle",   1, 0, 1, 0, 0, 0, O_IDLE);
      step("t_addr",   1, 0, 1, 0, 0, 0, O_ADDR);
      step("t_wait1",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("t_wait2",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("t_wait3",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("t_wait4",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("t_err1",   1, 1, 1, 1, 1, 0, O_ERR);
      step("t_err2",   1, 0, 1, 0, 0, 1, O_ERR);
      step("t_acked",  1, 0, 0, 0, 0, 0, O_IDLE);

      // mem_ready on the fourth wait cycle wins over the timeout
      step("r_idle",   1, 0, 1, 0, 0, 0, O_IDLE);
      step("r_addr",   1, 0, 1, 0, 0, 0, O_ADDR);
      step("r_wait1",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("r_wait2",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("r_wait3",  1, 0, 1, 0, 0, 0, O_WAIT);
      step("r_wait4",  1, 0, 1, 0, 1, 0, O_WAIT_R);
      step("r_data",   1, 0, 0, 0, 0, 0, O_L_DATA);
      step("r_after",  1, 0, 0, 0, 0, 0, O_IDLE);

      // Reset in F_WAIT, then a fetch with a fresh wait counter
      step("c_idle",   1, 0, 0, 1, 0, 0, O_IDLE);
      step("c_addr",   1, 0, 0, 1, 0, 0, O_F_ADDR);
      step("c_wait1",  1, 0, 0, 1, 0, 0, O_WAIT);
      step("c_wait2",  0, 0, 0, 1, 0, 0, O_WAIT);
      step("c_reset",  1, 0, 0, 0, 0, 0, O_IDLE);
      step("c2_idle",  1, 0, 0, 1, 0, 0, O_IDLE);
      step("c2_addr",  1, 0, 0, 1, 0, 0, O_F_ADDR);
      step("c2_wait1", 1, 0, 0, 1, 0, 0, O_WAIT);
      step("c2_wait2", 1, 0, 0, 1, 0, 0, O_WAIT);
      step("c2_wait3", 1, 0, 0, 1, 0, 0, O_WAIT);
      step("c2_wait4", 1, 0, 0, 1, 1, 0, O_WAIT_R);
      step("c2_ir",    1, 0, 0, 0, 0, 0, O_F_IR);
      step("c2_after", 1, 0, 0, 0, 0, 0, O_IDLE);

      // Store beats load; load runs once store_req is released
      step("sl_idle",  1, 1, 1, 0, 0, 0, O_IDLE);
      step("sl_saddr", 1, 1, 1, 0, 0, 0, O_ADDR);
      step("sl_sdata", 1, 1, 1, 0, 0, 0, O_S_DATA);
      step("sl_swait", 1, 1, 1, 0, 1, 0, O_S_WAIT);
      step("sl_send",  1, 0, 1, 0, 0, 0, O_S_END);
      step("sl_gap",   1, 0, 1, 0, 0, 0, O_IDLE);
      step("sl_laddr", 1, 0, 1, 0, 0, 0, O_ADDR);
      step("sl_lwait", 1, 0, 1, 0, 1, 0, O_WAIT_R);
      step("sl_ldata", 1, 0, 0, 0, 0, 0, O_L_DATA);
      step("sl_after", 1, 0, 0, 0, 0, 0, O_IDLE);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Moore-style controller that sequences the PC, MAR, MDR and IR registers and the external memory handshake for three operations: instruction fetch, data load and data store.
- Sits between the main control unit and the datapath register enables.
- The control unit raises one request level; this block drives the per-cycle register strobes, waits on memory with a timeout, and reports completion or error.

Parameters:
- TIMEOUT_CYCLES, 255, maximum wait-state cycles for mem_ready before the error state; legal range 1..255.
- TMR_W, 8, width of the wait counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  reset, synchronous, active-low; clear=0 at a rising edge resets the block.
- fetch_req  input  1  request an instruction fetch; level, held until done.
- load_req  input  1  request a data load; the datapath drives the address on the bus during L_ADDR.
- store_req  input  1  request a data store; the datapath drives the address in S_ADDR and the data in S_DATA.
- mem_ready  input  1  memory completed the current read or write.
- err_ack  input  1  clears a latched timeout error.
- pc_out  output  1  drive PC onto the bus.
- mar_in  output  1  MAR load enable.
- inc_pc  output  1  PC increment.
- mdr_read  output  1  MDR input-mux select: 1 = memory data, 0 = bus.
- mdr_in  output  1  MDR load enable.
- mdr_out  output  1  drive MDR onto the bus.
- ir_in  output  1  IR load enable.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- busy  output  1  high in every state except IDLE and ERR.
- done  output  1  one-cycle completion pulse.
- err_timeout  output  1  high while in ERR.

Behaviour:
- Reset: clear=0 at any edge, including mid-operation, forces state to IDLE, wait counter to 0 and all outputs to 0. No partial strobe survives the reset cycle.
- Outputs are decoded from state only (Moore). Every strobe not listed for a state is 0.
- IDLE: requests are sampled here only.
  - Priority: store_req > load_req > fetch_req.
  - The losing requests are ignored; the requester keeps holding them.
  - No request: stay in IDLE.
- Fetch sequence:
  - F_ADDR (1 cycle): pc_out, mar_in, inc_pc = 1. Go to F_WAIT.
  - F_WAIT: mem_read=1, mdr_read=1, mdr_in=mem_ready. On mem_ready go to F_IR.
  - F_IR (1 cycle): mdr_out=1, ir_in=1, done=1. Go to IDLE.
- Load sequence:
  - L_ADDR (1 cycle): mar_in=1.
  - L_WAIT: same outputs as F_WAIT.
  - L_DATA (1 cycle): mdr_out=1, done=1. Go to IDLE.
- Store sequence:
  - S_ADDR (1 cycle): mar_in=1.
  - S_DATA (1 cycle): mdr_in=1, mdr_read=0.
  - S_WAIT: mem_write=1 until mem_ready, then S_END.
  - S_END (1 cycle): done=1. Go to IDLE.
- Latency: fetch and load take at least 3 cycles after leaving IDLE; store takes at least 4. Each extra cycle without mem_ready adds 1.
- Wait counter:
  - Cleared on entry to any *_WAIT state; increments each wait cycle while mem_ready=0.
  - If it reaches TIMEOUT_CYCLES-1 with mem_ready still 0, the next state is ERR.
  - mem_ready in that same cycle wins over the timeout.
- ERR: err_timeout=1, all strobes 0, requests ignored. err_ack=1 returns to IDLE on the next edge.
- A fetch's inc_pc is not undone on timeout.
- Back-to-back operations: a request held after done is re-accepted in the IDLE cycle following done. There is therefore at least one idle cycle between operations.
- mem_ready outside the wait states is ignored.

Decomposition:
- Shared package: state enumeration (IDLE, F_ADDR, F_WAIT, F_IR, L_ADDR, L_WAIT, L_DATA, S_ADDR, S_DATA, S_WAIT, S_END, ERR) and a default TIMEOUT_CYCLES constant.
- One sub-module, wait_timer: TMR_W-bit counter with clear/increment/expired, same clock and active-low synchronous clear.

Test Plan:
- Fetch, mem_ready high 2 cycles after F_WAIT entry:
  - pc_out, mar_in and inc_pc high exactly 1 cycle.
  - mem_read high 3 cycles; mdr_in high on the final wait cycle only.
  - ir_in and done pulse together, 5 cycles after leaving IDLE.
- load_req and fetch_req raised together:
  - load sequence runs (mar_in without pc_out; done with mdr_out, no ir_in).
  - Fetch starts in the IDLE cycle after done.
- Store with mem_ready immediate:
  - S_DATA has mdr_in=1, mdr_read=0.
  - mem_write high 1 cycle; done 4 cycles after leaving IDLE.
- TIMEOUT_CYCLES=4, mem_ready held 0 during a load:
  - After 4 wait cycles err_timeout=1, busy=0 and all strobes 0.
  - err_ack returns to IDLE.
  - Repeat with mem_ready on the 4th wait cycle: no error.
- clear=0 asserted in F_WAIT:
  - Next cycle all outputs 0, state IDLE.
  - A later fetch starts with the wait counter at 0.
- store_req and load_req both held: store completes first; load runs after release of store_req.
